// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg
// Shared definitions for the dmem load/store unit:
//   - RV32I funct3 encodings for loads and stores
//   - FSM state enum
//   - MEM_AW, the dmem word-address width (64 words)
package dmem_lsu_pkg;

    localparam int MEM_AW = 6;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   chkFunct3_i, chkStore_i, chkAddr_i : request being checked for legality
//   legal_o                            : 1 when alignment and funct3 are valid
//   funct3_i, addr_i                   : latched access type and byte offset
//   storeLo_i                          : low halfword of the latched store data
//   memRdata_i                         : current dmem read word
//   loadData_o                         : extracted and extended load result
//   mergeData_o                        : read word with the store lanes replaced
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  chkFunct3_i,
    input  logic        chkStore_i,
    input  logic [1:0]  chkAddr_i,
    output logic        legal_o,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [15:0] storeLo_i,
    input  logic [31:0] memRdata_i,
    output logic [31:0] loadData_o,
    output logic [31:0] mergeData_o
);

    logic [4:0]  laneShift;
    logic [31:0] shiftedWord;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] laneMask;
    logic [31:0] laneData;

    // Bit offset of the addressed lane; the selected byte/halfword always
    // ends up in the low bits of shiftedWord.
    assign laneShift   = {addr_i, 3'b000};
    assign shiftedWord = memRdata_i >> laneShift;
    assign laneByte    = shiftedWord[7:0];
    assign laneHalf    = shiftedWord[15:0];

    // Legality: stores and loads have separate encoding sets, so a load
    // using a store-only code (and vice versa) falls into the default arm.
    always_comb begin
        legal_o = 1'b0;
        if (chkStore_i) begin
            case (chkFunct3_i)
                F3_SB:   legal_o = 1'b1;
                F3_SH:   legal_o = ~chkAddr_i[0];
                F3_SW:   legal_o = (chkAddr_i == 2'b00);
                default: legal_o = 1'b0;
            endcase
        end else begin
            case (chkFunct3_i)
                F3_LB, F3_LBU: legal_o = 1'b1;
                F3_LH, F3_LHU: legal_o = ~chkAddr_i[0];
                F3_LW:         legal_o = (chkAddr_i == 2'b00);
                default:       legal_o = 1'b0;
            endcase
        end
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        loadData_o = 32'h0;
        case (funct3_i)
            F3_LB:   loadData_o = {{24{laneByte[7]}}, laneByte};
            F3_LH:   loadData_o = {{16{laneHalf[15]}}, laneHalf};
            F3_LW:   loadData_o = memRdata_i;
            F3_LBU:  loadData_o = {24'h0, laneByte};
            F3_LHU:  loadData_o = {16'h0, laneHalf};
            default: loadData_o = 32'h0;
        endcase
    end

    // Store merge: clear the target lane in the read word and OR in the
    // new data shifted into the same position.
    always_comb begin
        laneMask = 32'h0;
        laneData = 32'h0;
        case (funct3_i)
            F3_SB: begin
                laneMask = 32'h0000_00FF << laneShift;
                laneData = {24'h0, storeLo_i[7:0]} << laneShift;
            end
            F3_SH: begin
                laneMask = 32'h0000_FFFF << laneShift;
                laneData = {16'h0, storeLo_i} << laneShift;
            end
            default: begin
                laneMask = 32'h0;
                laneData = 32'h0;
            end
        endcase
        mergeData_o = (memRdata_i & ~laneMask) | laneData;
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu
// Load/store unit between the execute stage and the 64-word dmem.
// One transaction at a time: IDLE -> (ACCESS [-> WRITE]) -> RESP -> IDLE.
// Sub-word stores are read-modify-write because dmem only writes words.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_funct3, req_store          : access type
//   req_addr, req_wdata            : byte address and store data
//   rsp_valid/rsp_ready            : registered response handshake
//   rsp_rdata, rsp_err             : load result / error flag
//   mem_addr, mem_wdata, mem_we    : dmem word address, write data, enable
//   mem_rdata                      : dmem combinational read data
// Build option:
//   DMEM_LSU_RANGE_CHECK_EN : flag requests with req_addr[31:8] != 0 as
//                             errors; otherwise addresses wrap at 256 bytes.
module dmem_lsu
    import dmem_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic              req_store,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        reqLegal;
    logic        rangeErr;
    logic [31:0] loadData;
    logic [31:0] mergeData;

`ifdef DMEM_LSU_RANGE_CHECK_EN
    assign rangeErr = |req_addr[31:8];
`else
    // Upper address bits are intentionally dropped so accesses wrap.
    logic unusedAddrHi;
    assign unusedAddrHi = ^req_addr[31:8];
    assign rangeErr     = 1'b0;
`endif

    // Legality is judged on the live request inputs in IDLE; lane
    // extraction and merging work on the latched transaction.
    dmem_lsu_align u_align (
        .chkFunct3_i (req_funct3),
        .chkStore_i  (req_store),
        .chkAddr_i   (req_addr[1:0]),
        .legal_o     (reqLegal),
        .funct3_i    (funct3_q),
        .addr_i      (addr_q[1:0]),
        .storeLo_i   (wdata_q[15:0]),
        .memRdata_i  (mem_rdata),
        .loadData_o  (loadData),
        .mergeData_o (mergeData)
    );

    // State and transaction registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state and memory-side outputs. mem_we is asserted only in
    // ACCESS for a full-word store and in WRITE for the merged word.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        store_d   = store_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    store_d  = req_store;
                    addr_d   = req_addr[7:0];
                    wdata_d  = req_wdata;
                    if (!reqLegal || rangeErr) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!store_q) begin
                    rdata_d = loadData;
                    state_d = ST_RESP;
                end else if (funct3_q == F3_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = ST_RESP;
                end else begin
                    merge_d = mergeData;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = merge_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q[MEM_AW+1:2];

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
// Scoreboard bench for dmem_lsu with a behavioural 64-word dmem.
// The driver pushes the expected response of each request into a queue;
// an independent monitor pops and compares on every response, including
// response latency and the memory write issued for the transaction.
module tb_dmem_lsu;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          weCyc;
        logic [5:0]  weAddr;
        logic [31:0] weData;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic        req_store = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];

    exp_t expQ[$];
    int   nCompared = 0;
    int   nFail = 0;
    int   edgeCnt = 0;
    logic enMon = 1'b0;

    dmem_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Behavioural dmem: preload, then word writes on the rising edge.
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1]  = 32'hCAFE_F00D;
        mem[3]  = 32'h8899_AABB;
        mem[5]  = 32'h0BAD_BEEF;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                     name, act, expv, $time);
        end
    endtask

    // Issue one request and queue its expected response. Called just after
    // a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int expLat, input int expWeCyc,
                                 input logic [5:0] expWeAddr,
                                 input logic [31:0] expWeData);
        exp_t e;
        logic accepted;
        e.rdata  = expRdata;
        e.err    = expErr;
        e.lat    = expLat;
        e.weCyc  = expWeCyc;
        e.weAddr = expWeAddr;
        e.weData = expWeData;
        expQ.push_back(e);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        accepted   = 1'b0;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end else begin
            nCompared++;
            nFail++;
            $display("[TB] FAIL req_accept_timeout: req_ready stayed 0, expected 1");
            void'(expQ.pop_back());
        end
        req_valid = 1'b0;
    endtask

    task automatic drainQueue(input string name);
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: tracks accepts, memory writes and responses independently
    // of the driver, and compares each response against the queue head.
    initial begin : monitor
        logic        busy;
        logic        seen;
        int          acceptCyc;
        int          weCnt;
        int          weCycRec;
        logic [5:0]  weAddrRec;
        logic [31:0] weDataRec;
        exp_t        e;
        busy = 1'b0;
        seen = 1'b0;
        acceptCyc = 0;
        weCnt = 0;
        weCycRec = 0;
        weAddrRec = 6'h0;
        weDataRec = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy  = 1'b0;
                seen  = 1'b0;
                weCnt = 0;
            end else begin
                if (enMon) checkOutput("req_ready", 32'(req_ready), 32'(!busy));
                if (mem_we) begin
                    weCnt++;
                    weCycRec  = edgeCnt - acceptCyc;
                    weAddrRec = mem_addr;
                    weDataRec = mem_wdata;
                end
                if (rsp_valid && enMon) begin
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nFail++;
                        $display("[TB] FAIL unexpected_rsp: rsp_valid=1, expected 0");
                    end else begin
                        e = expQ[0];
                        if (!seen) checkOutput("rsp_latency", 32'(edgeCnt - acceptCyc), 32'(e.lat));
                        seen = 1'b1;
                        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (rsp_ready) begin
                            checkOutput("we_count", 32'(weCnt), (e.weCyc != 0) ? 32'd1 : 32'd0);
                            if (e.weCyc != 0) begin
                                checkOutput("we_cycle", 32'(weCycRec), 32'(e.weCyc));
                                checkOutput("we_addr", 32'(weAddrRec), 32'(e.weAddr));
                                checkOutput("we_data", weDataRec, e.weData);
                            end
                            void'(expQ.pop_front());
                            busy = 1'b0;
                            seen = 1'b0;
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    busy      = 1'b1;
                    acceptCyc = edgeCnt;
                    weCnt     = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        enMon = 1'b1;

        // Load extension over word 3 = 0x8899AABB
        applyStimulus(1'b0, LB,  32'h0D, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, LBU, 32'h0D, 32'h0, 32'h0000_00AA, 1'b0, 2, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, LHU, 32'h0E, 32'h0, 32'h0000_8899, 1'b0, 2, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, LH,  32'h0E, 32'h0, 32'hFFFF_8899, 1'b0, 2, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, LW,  32'h0C, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 6'd0, 32'h0);

        // SB read-modify-write, then read back
        applyStimulus(1'b1, SB,  32'h0E, 32'hDEAD_BE55, 32'h0, 1'b0, 3, 2, 6'd3, 32'h8855_AABB);
        applyStimulus(1'b0, LW,  32'h0C, 32'h0, 32'h8855_AABB, 1'b0, 2, 0, 6'd0, 32'h0);

        // SH into word 0, then sub-word reads of the new halfword
        applyStimulus(1'b1, SH,  32'h02, 32'hFFFF_BEEF, 32'h0, 1'b0, 3, 2, 6'd0, 32'hBEEF_0000);
        applyStimulus(1'b0, LHU, 32'h02, 32'h0, 32'h0000_BEEF, 1'b0, 2, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, LB,  32'h03, 32'h0, 32'hFFFF_FFBE, 1'b0, 2, 0, 6'd0, 32'h0);

        // Misaligned and illegal encodings
        applyStimulus(1'b0, LW,     32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);
        applyStimulus(1'b1, SH,     32'h03, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, LH,     32'h05, 32'h0, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h00, 32'h1, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);
        applyStimulus(1'b1, 3'b101, 32'h00, 32'h1, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);

        // Backpressure: SW held in RESP while a second request waits
        drainQueue("drain_before_bp");
        rsp_ready = 1'b0;
        applyStimulus(1'b1, SW, 32'hFC, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 6'd63, 32'h1234_5678);
        fork
            applyStimulus(1'b0, LW, 32'hFC, 32'h0, 32'h1234_5678, 1'b0, 2, 0, 6'd0, 32'h0);
            begin
                for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join

        // Range check / wrap
`ifdef DMEM_LSU_RANGE_CHECK_EN
        applyStimulus(1'b0, LW, 32'h0000_0104, 32'h0, 32'h0, 1'b1, 1, 0, 6'd0, 32'h0);
`else
        applyStimulus(1'b0, LW, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0, 6'd0, 32'h0);
`endif

        // Reset while an SH sits in WRITE: the write must not land.
        drainQueue("drain_before_reset");
        enMon      = 1'b0;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = SH;
        req_addr   = 32'h14;
        req_wdata  = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_we_before", 32'(mem_we), 32'd1);
        checkOutput("abort_wdata_before", mem_wdata, 32'h0BAD_1234);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("abort_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
        checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("abort_mem_word5", mem[5], 32'h0BAD_BEEF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_idle_ready", 32'(req_ready), 32'd1);
        enMon = 1'b1;
        applyStimulus(1'b0, LW, 32'h14, 32'h0, 32'h0BAD_BEEF, 1'b0, 2, 0, 6'd0, 32'h0);
        drainQueue("drain_final");

        checkOutput("mem_word63", mem[63], 32'h1234_5678);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule
